// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one external 32-bit ALU between NUM_REQ requesters
module alu_share_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_src1,
    input  logic [32*NUM_REQ-1:0] req_src2,
    input  logic [4*NUM_REQ-1:0]  req_ctrl,
    input  logic [3*NUM_REQ-1:0]  req_bonus,
    output logic                  alu_rst_n,
    output logic [31:0]           alu_src1,
    output logic [31:0]           alu_src2,
    output logic [3:0]            alu_ctrl,
    output logic [2:0]            alu_bonus,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_cout,
    input  logic                  alu_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic [2:0]            rsp_flags,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic              r_bad;
    logic [31:0]       r_alu_src1;
    logic [31:0]       r_alu_src2;
    logic [3:0]        r_alu_ctrl;
    logic [2:0]        r_alu_bonus;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [31:0]       r_rsp_result;
    logic [2:0]        r_rsp_flags;
    logic              r_rsp_err;

    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W:0]     w_sum;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [31:0]       w_src1;
    logic [31:0]       w_src2;
    logic [3:0]        w_ctrl;
    logic [2:0]        w_bonus;
    logic              w_legal;

    function automatic logic f_legal(input logic [3:0] c, input logic [2:0] b);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101: f_legal = 1'b1;
            4'b0111: f_legal = (b != 3'b101) && (b != 3'b111);
            default: f_legal = 1'b0;
        endcase
    endfunction

    // Walk downward from the farthest offset so the nearest valid index after ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            if (req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_found)
            req_ready[w_idx] = 1'b1;
    end

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_src1    = req_src1[w_idx*32 +: 32];
    assign w_src2    = req_src2[w_idx*32 +: 32];
    assign w_ctrl    = req_ctrl[w_idx*4 +: 4];
    assign w_bonus   = req_bonus[w_idx*3 +: 3];
    assign w_legal   = f_legal(w_ctrl, w_bonus);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_bad        <= 1'b0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_ctrl   <= '0;
            r_alu_bonus  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        // Illegal codes leave the ALU inputs untouched.
                        if (w_legal) begin
                            r_alu_src1  <= w_src1;
                            r_alu_src2  <= w_src2;
                            r_alu_ctrl  <= w_ctrl;
                            r_alu_bonus <= w_bonus;
                        end
                        r_bad    <= ~w_legal;
                        r_rsp_id <= w_idx;
                        r_ptr    <= w_ptr_nxt;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_bad) begin
                        r_rsp_result <= '0;
                        r_rsp_flags  <= '0;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= {alu_overflow, alu_cout, alu_zero};
                        r_rsp_err    <= 1'b0;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_rst_n  = ~rst;
    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_ctrl   = r_alu_ctrl;
    assign alu_bonus  = r_alu_bonus;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

endmodule
